// File: rtl/encoder_round_sequencer.sv
// Control sequencer for the 25-bit matrix-encoder datapath: fetches a line,
// runs ROUNDS x STEPS sub-steps on it, hands it to the sink, repeats per job.
module encoder_round_sequencer #(
    parameter int unsigned ROUNDS = 24,
    parameter int unsigned STEPS  = 3,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned RW     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_lines,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             state_en,
    output logic             mux_sel,
    output logic             step_en,
    output logic [1:0]       step_sel,
    output logic [RW-1:0]    round_idx,
    output logic [CNT_W-1:0] line_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SW = 2;
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [RW-1:0]    round_q, round_d;
    logic [CNT_W-1:0] line_q, line_d;
    logic [CNT_W-1:0] count_q, count_d;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            round_q <= '0;
            line_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            round_q <= round_d;
            line_q  <= line_d;
            count_q <= count_d;
        end
    end

    // Next-state and control decode; only state_en in LOAD follows an input directly
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        round_d   = round_q;
        line_d    = line_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        state_en  = 1'b0;
        mux_sel   = 1'b0;
        step_en   = 1'b0;
        step_sel  = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_lines != '0) begin
                        count_d = num_lines;
                        line_d  = '0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                state_en = in_valid;
                if (in_valid) begin
                    step_d  = '0;
                    round_d = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                busy     = 1'b1;
                step_en  = 1'b1;
                state_en = 1'b1;
                mux_sel  = 1'b1;
                step_sel = step_q;
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    if (round_q == ROUND_LAST) begin
                        round_d = '0;
                        state_d = S_WRITE;
                    end else begin
                        round_d = round_q + RW'(1);
                    end
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    line_d  = line_q + CNT_W'(1);
                    state_d = (line_d == count_q) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign round_idx = round_q;
    assign line_idx  = line_q;

endmodule
